rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N-input, W-bit registered mux with round-robin arbitration and valid/ready handshake.
//  Successor to the fixed combinational select muxes: picks the input itself (fair rotation), registers
//  the result, and holds it until the consumer takes it. Merges requesters (e.g. I/D-mem miss paths,
//  writeback sources) onto one shared bus.
// PARAMETERS
//  NUM_IN   4   number of input channels (>=2)
//  WIDTH    16  data width per channel (>=1)
//  SEL_W    $clog2(NUM_IN)  derived, do not override; width of out_sel / rotation pointer
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   NUM_IN         per-channel request; bit i = channel i
//  in_data    in   NUM_IN*WIDTH   packed data; channel i at [i*WIDTH +: WIDTH]
//  in_ready   out  NUM_IN         one-hot (or zero) grant/accept to channel i
//  out_valid  out  1              output register holds a beat
//  out_data   out  WIDTH          registered data of winning channel
//  out_sel    out  SEL_W          index of channel that supplied out_data
//  out_ready  in   1              consumer accepts beat when out_valid & out_ready
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is 0 while rst=1.
//  - space = !out_valid | out_ready (output reg empty or being drained this cycle).
//  - Arbitration (combinational): winner = first i with in_valid[i], searching ptr, ptr+1, ... wrapping
//    modulo NUM_IN. in_ready = onehot(winner) & {NUM_IN{space}}; all zero if no in_valid.
//  - Accept: any in_valid[i]&in_ready[i]. On accept at edge: out_valid<=1, out_data<=in_data[winner],
//    out_sel<=winner, ptr<=(winner+1) mod NUM_IN (wrap: winner=NUM_IN-1 -> ptr=0).
//  - Drain without accept: out_valid<=0; out_data/out_sel keep last value.
//  - Stall (out_valid & !out_ready): out_valid/out_data/out_sel/ptr unchanged; in_ready=0.
//  - Simultaneous drain+accept: both occur same cycle; full throughput, 1 beat/cycle.
//  - Latency: accepted beat visible on out_* the cycle after acceptance.
//  - ptr advances only on accept; idle cycles never rotate it.
//  - Inputs must hold in_valid/in_data until accepted; block does not check this.
//  - Reset mid-stall discards the held beat; no beat is emitted after reset until a new accept.
//  - Fairness: with all NUM_IN inputs valid continuously, grants cycle 0,1,..,N-1,0,... no starvation.
// CONFIGURATION
//  ARB_MUX_LOCK_EN defined: adds port in_last (in, NUM_IN). On accept with in_last[winner]=0 the
//    grant locks: ptr is not advanced and arbitration is restricted to that channel (in_ready only to
//    it, even if others valid) until a beat with in_last=1 is accepted, then ptr<=winner+1 as usual.
//    Lock flag resets to 0. Used for multi-beat transfers (e.g. cache line fills).
//  ARB_MUX_LOCK_EN undefined: no in_last port; every beat is independently arbitrated as above.
// TESTING
//  1 Reset: rst=1 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0 after edge.
//  2 Rotation: in_valid=4'b1111 held, out_ready=1, data ch i=16'hA0+i -> out_sel 0,1,2,3,0 on
//    consecutive cycles, out_data A0,A1,A2,A3,A0; out_valid stays 1.
//  3 Backpressure: out_ready=0 after first beat (ch1, 16'h1234) -> out_data stays 1234, in_ready=0
//    for 5 cycles; release -> next beat accepted in same cycle as drain, no bubble.
//  4 Wrap/skip: ptr=3, in_valid=4'b0010 -> ch1 wins, ptr becomes 2; then in_valid=4'b1001 -> ch3 wins.
//  5 Reset mid-stall: out_valid=1, out_ready=0, pulse rst -> out_valid=0, ptr=0, held beat lost.
//  6 (ARB_MUX_LOCK_EN) ch2 sends 3 beats in_last=0,0,1 while ch0,ch1,ch3 valid -> out_sel=2,2,2,
//    then 3; without macro same stimulus -> out_sel=2,3,0,...

Source files
------------

// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//   N-input, W-bit registered multiplexer with round-robin arbitration and a
//   valid/ready handshake on both sides. The block chooses an input itself,
//   captures its data into a single output register and holds that beat until
//   the consumer accepts it. New beats can be captured in the same cycle the
//   held beat drains, so the block sustains one beat per cycle.
//
//   Arbitration searches upward from a rotation pointer, wrapping modulo
//   NUM_IN. The pointer moves to (winner + 1) only when a beat is accepted,
//   so idle cycles never rotate it. With every input requesting continuously,
//   grants cycle 0, 1, ..., NUM_IN-1, 0, ... and no channel starves.
//
// Parameters
//   NUM_IN  number of input channels (>= 2)
//   WIDTH   data width per channel (>= 1)
//   SEL_W   derived width of out_sel and the rotation pointer; do not override
//
// Ports
//   clk        in   1             clock, all state updates on the rising edge
//   rst        in   1             synchronous, active-high reset
//   in_valid   in   NUM_IN        per-channel request, bit i = channel i
//   in_data    in   NUM_IN*WIDTH  packed data, channel i at [i*WIDTH +: WIDTH]
//   in_last    in   NUM_IN        (ARB_MUX_LOCK_EN only) last beat of a burst
//   in_ready   out  NUM_IN        one-hot (or zero) grant to the winning channel
//   out_valid  out  1             output register holds a beat
//   out_data   out  WIDTH         registered data of the winning channel
//   out_sel    out  SEL_W         index of the channel that supplied out_data
//   out_ready  in   1             consumer takes the beat when out_valid is high
//
// Build option
//   ARB_MUX_LOCK_EN  When defined, adds in_last. Accepting a beat with
//                    in_last[winner] = 0 locks the grant onto that channel
//                    (pointer frozen, other requesters ignored) until a beat
//                    with in_last = 1 is accepted from it. Intended for
//                    multi-beat transfers such as cache line fills. When
//                    undefined, every beat is arbitrated independently.
// -----------------------------------------------------------------------------
module rr_arb_mux #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 16,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
`endif
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] ptr;        // first channel examined by the next search
`ifdef ARB_MUX_LOCK_EN
  logic             lock_q;     // a multi-beat burst owns the output
  logic [SEL_W-1:0] lock_ch;    // channel owning the burst while lock_q is set
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic             space;      // output register empty or draining this cycle
  logic             found;      // some eligible channel is requesting
  logic [SEL_W-1:0] winner;     // index of the selected channel (valid if found)
  logic             accept;     // a beat moves into the output register
  logic [SEL_W-1:0] ptr_next;   // pointer value after accepting from winner
  logic [SEL_W:0]   idx;        // ptr + k, one spare bit to detect the wrap

  assign space = !out_valid || out_ready;

  // NOTE: always_comb uses blocking assignments so each statement sees the
  // value produced by the one before it (the priority search relies on this);
  // sequential blocks below use non-blocking assignments only.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the search leaves one unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
`ifdef ARB_MUX_LOCK_EN
    if (lock_q) begin
      // Mid-burst: only the owning channel is eligible.
      found  = in_valid[lock_ch];
      winner = lock_ch;
    end else
`endif
    begin
      // Search ptr, ptr+1, ... wrapping modulo NUM_IN. ptr < NUM_IN and
      // k < NUM_IN, so a single conditional subtraction performs the wrap
      // and also handles non power-of-two channel counts.
      for (int k = 0; k < NUM_IN; k++) begin
        idx = {1'b0, ptr} + (SEL_W+1)'(k);
        if (idx >= (SEL_W+1)'(NUM_IN)) begin
          idx = idx - (SEL_W+1)'(NUM_IN);
        end
        if (!found && in_valid[idx[SEL_W-1:0]]) begin
          found  = 1'b1;
          winner = idx[SEL_W-1:0];
        end
      end
    end
  end

  // Grant only when the output register can take a beat, never during reset.
  always_comb begin
    in_ready = '0;
    if (found && space && !rst) begin
      in_ready[winner] = 1'b1;
    end
  end

  assign accept   = found && space && !rst;
  assign ptr_next = (winner == SEL_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;

  // ---------------------------------------------------------------------------
  // Output register and rotation pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // A beat held at reset is discarded; nothing is emitted afterwards
      // until a fresh accept.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[winner*WIDTH +: WIDTH];
      out_sel   <= winner;
`ifdef ARB_MUX_LOCK_EN
      // The pointer stays put for every beat of a burst except the last.
      if (in_last[winner]) begin
        ptr <= ptr_next;
      end
`else
      ptr       <= ptr_next;
`endif
    end else if (out_ready) begin
      // Drain without refill: data and select keep their last values.
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
    end else if (accept) begin
      lock_q  <= !in_last[winner];
      lock_ch <= winner;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_grant_onehot : assert property (@(posedge clk) $onehot0(in_ready));

  a_stall_holds : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
//   Self-checking bench for rr_arb_mux (NUM_IN = 4, WIDTH = 16). A reference
//   model built from the arbitration rules (integer pointer, modulo search)
//   predicts in_ready before each edge and out_* after it. Directed sequences
//   cover reset, rotation, backpressure, wrap/skip, reset mid-stall and
//   multi-beat locking; a randomized phase follows. Honors ARB_MUX_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

  localparam int NUM_IN = 4;
  localparam int WIDTH  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_sel;
  logic                    out_ready;

  rr_arb_mux #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  int              m_ptr;
  int              m_ov;
  int              m_os;
  logic [WIDTH-1:0] m_od;
  int              m_lock;
  int              m_lch;
  logic [NUM_IN-1:0] last_grant;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requesting channel from the pointer onward, or -1.
  function automatic int ref_winner();
    if (m_lock != 0) return in_valid[m_lch] ? m_lch : -1;
    for (int k = 0; k < NUM_IN; k++) begin
      int c;
      c = (m_ptr + k) % NUM_IN;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check grant before the edge, advance model, check outputs after.
  task automatic step();
    int                win;
    bit                space;
    logic [NUM_IN-1:0] exp_ready;
    #1;
    space     = (m_ov == 0) || out_ready;
    win       = ref_winner();
    exp_ready = (!rst && space && win >= 0) ? NUM_IN'(1 << win) : '0;
    check("in_ready", in_ready, exp_ready);
    last_grant = exp_ready;
    @(posedge clk);
    if (rst) begin
      m_ov = 0; m_od = '0; m_os = 0; m_ptr = 0; m_lock = 0; m_lch = 0;
    end else if (exp_ready != 0) begin
      m_ov = 1;
      m_od = in_data[win*WIDTH +: WIDTH];
      m_os = win;
`ifdef ARB_MUX_LOCK_EN
      if (!in_last[win]) begin
        m_lock = 1; m_lch = win;
      end else begin
        m_lock = 0; m_ptr = (win + 1) % NUM_IN;
      end
`else
      m_ptr = (win + 1) % NUM_IN;
`endif
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_sel", out_sel, m_os);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp6 [4];
    m_ptr = 0; m_ov = 0; m_os = 0; m_od = '0; m_lock = 0; m_lch = 0;
    last_grant = '0;
    in_valid = '0; in_data = '0; in_last = '1; out_ready = 1'b0; rst = 1'b1;

    // 1: reset with all channels requesting
    in_valid = 4'b1111;
    step();
    check("rst_ready", in_ready, 4'b0000);
    check("rst_ov", out_valid, 1'b0);
    check("rst_od", out_data, 16'h0);
    check("rst_os", out_sel, 2'd0);
    rst = 1'b0;

    // 2: rotation with all channels valid and a free consumer
    for (int c = 0; c < NUM_IN; c++) set_data(c, 16'(16'hA0 + c));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rot_sel", out_sel, 32'(i % NUM_IN));
      check("rot_data", out_data, 32'(16'hA0 + i % NUM_IN));
    end

    // 3: backpressure after first beat from ch1
    in_valid = '0;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_data(1, 16'h1234);
    step();
    in_valid = 4'b0100;
    set_data(2, 16'h5678);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_data", out_data, 16'h1234);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 4'b0100);
    step();
    check("bp_next_data", out_data, 16'h5678);
    check("bp_no_bubble", out_valid, 1'b1);

    // 5: reset mid-stall discards the held beat and clears the pointer
    in_valid  = '0;
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rst_stall_ov", out_valid, 1'b0);
    rst = 1'b0;
    step();
    check("rst_no_beat", out_valid, 1'b0);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    check("rst_ptr_zero", out_sel, 2'd0);

    // 4: wrap/skip
    in_valid = '0;
    do_reset();
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0010;
    step();
    check("skip_ch1", out_sel, 2'd1);
    in_valid = 4'b1001;
    step();
    check("wrap_ch3", out_sel, 2'd3);

    // 6: burst of three beats from ch2 while everyone else requests
`ifdef ARB_MUX_LOCK_EN
    exp6 = '{2, 2, 2, 3};
`else
    exp6 = '{2, 3, 0, 1};
`endif
    in_valid = '0;
    do_reset();
    in_last  = '1;
    in_valid = 4'b0010;
    step();
    in_valid = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      in_last[2] = (b >= 2);
      step();
      check("burst_sel", out_sel, 32'(exp6[b]));
    end

    // Randomized phase: requests hold until granted
    in_valid = '0;
    in_last  = '1;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NUM_IN; c++) begin
        if (!in_valid[c] && $urandom_range(0, 2) == 0) begin
          in_valid[c] = 1'b1;
          set_data(c, 16'($urandom));
          in_last[c]  = ($urandom_range(0, 2) != 0);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
      in_valid = in_valid & ~last_grant;
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
